cluster_pwr_seq: RTL and testbench

//  Sequences power-up, clock enable, reset release, fetch enable and drain of the

---
 rtl/cluster_pwr_seq_if.sv | 31 +++
 rtl/cluster_pwr_seq.sv | 195 +++++++++++++++++++
 tb/tb_cluster_pwr_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cluster_pwr_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : cluster_pwr_seq_if
// Description : Request channel between the FC and the cluster power
//               sequencer: valid/ready handshake carrying the on/off command
//               and the cluster boot address.
// Revision    : 1.0 - initial release
// ============================================================================
interface cluster_pwr_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_on;
    logic [63:0] boot_addr;

    // Requester side (FC / testbench)
    modport master (
        output req_valid,
        output req_on,
        output boot_addr,
        input  req_ready
    );

    // Sequencer side
    modport slave (
        input  req_valid,
        input  req_on,
        input  boot_addr,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/cluster_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : cluster_pwr_seq
// Description : Sequences cluster power-up (power, clock, reset release,
//               fetch enable) and power-down (fetch off, drain on busy with
//               timeout, reset assert, clock off, power off). One request at
//               a time over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module cluster_pwr_seq #(
    parameter int PWR_CYCLES   = 16,
    parameter int CLK_CYCLES   = 4,
    parameter int RST_CYCLES   = 8,
    parameter int BUSY_TIMEOUT = 1024,
    parameter int CNT_W        = 16
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    cluster_pwr_seq_if.slave   req_if,
    input  wire logic          cluster_busy_i,
    output logic               cluster_pow_o,
    output logic               cluster_clk_en_o,
    output logic               cluster_rstn_o,
    output logic               cluster_fetch_enable_o,
    output logic [63:0]        cluster_boot_addr_o,
    output logic               done_o,
    output logic               err_timeout_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        S_OFF        = 3'd0,
        S_PWR_UP     = 3'd1,
        S_CLK_ON     = 3'd2,
        S_RST_REL    = 3'd3,
        S_RUN        = 3'd4,
        S_DRAIN      = 3'd5,
        S_RST_ASSERT = 3'd6,
        S_PWR_DOWN   = 3'd7
    } state_t;

    // Counter load values: a timed state lasting N cycles loads N-1 on entry
    localparam logic [CNT_W-1:0] PWR_LOAD  = CNT_W'(PWR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLK_LOAD  = CNT_W'(CLK_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_TIMEOUT - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               pow_q;
    logic               clk_en_q;
    logic               rstn_q;
    logic               fetch_q;
    logic [63:0]        boot_q;
    logic               done_q;
    logic               err_q;

    logic               w_ready;
    logic               w_accept;
    logic               w_cnt_zero;

    // Requests are only taken while idle (OFF) or running (RUN)
    assign w_ready    = (state_q == S_OFF) || (state_q == S_RUN);
    assign w_accept   = req_if.req_valid && w_ready;
    assign w_cnt_zero = (cnt_q == '0);

    assign req_if.req_ready        = w_ready;
    assign cluster_pow_o           = pow_q;
    assign cluster_clk_en_o        = clk_en_q;
    assign cluster_rstn_o          = rstn_q;
    assign cluster_fetch_enable_o  = fetch_q;
    assign cluster_boot_addr_o     = boot_q;
    assign done_o                  = done_q;
    assign err_timeout_o           = err_q;
    assign state_o                 = state_q;

    // Sequencer FSM with registered cluster controls, done pulse and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            pow_q    <= 1'b0;
            clk_en_q <= 1'b0;
            rstn_q   <= 1'b0;
            fetch_q  <= 1'b0;
            boot_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Any accepted request acknowledges a previous drain timeout
            if (w_accept) begin
                err_q <= 1'b0;
            end

            case (state_q)
                S_OFF: begin
                    if (w_accept) begin
                        if (req_if.req_on) begin
                            state_q <= S_PWR_UP;
                            cnt_q   <= PWR_LOAD;
                            pow_q   <= 1'b1;
                            boot_q  <= req_if.boot_addr;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end

                S_PWR_UP: begin
                    if (w_cnt_zero) begin
                        state_q  <= S_CLK_ON;
                        cnt_q    <= CLK_LOAD;
                        clk_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_CLK_ON: begin
                    if (w_cnt_zero) begin
                        state_q <= S_RST_REL;
                        cnt_q   <= RST_LOAD;
                        rstn_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_RST_REL: begin
                    if (w_cnt_zero) begin
                        state_q <= S_RUN;
                        fetch_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_RUN: begin
                    if (w_accept) begin
                        if (req_if.req_on) begin
                            // Already running: acknowledge, keep boot address
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                            cnt_q   <= BUSY_LOAD;
                            fetch_q <= 1'b0;
                        end
                    end
                end

                S_DRAIN: begin
                    // Idle cluster wins over timeout when both happen together
                    if (!cluster_busy_i || w_cnt_zero) begin
                        state_q <= S_RST_ASSERT;
                        cnt_q   <= RST_LOAD;
                        rstn_q  <= 1'b0;
                        if (cluster_busy_i) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_RST_ASSERT: begin
                    if (w_cnt_zero) begin
                        state_q  <= S_PWR_DOWN;
                        cnt_q    <= PWR_LOAD;
                        clk_en_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_PWR_DOWN: begin
                    if (w_cnt_zero) begin
                        state_q <= S_OFF;
                        pow_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_q <= S_OFF;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cluster_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cluster_pwr_seq
// Description : Scoreboard bench for cluster_pwr_seq. A request model predicts
//               completion time, final control levels and transition times;
//               a monitor checks them on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cluster_pwr_seq;
    localparam int P  = 16;
    localparam int C  = 4;
    localparam int R  = 8;
    localparam int BT = 1024;

    localparam int K_NOOP_OFF = 0;
    localparam int K_NOOP_RUN = 1;
    localparam int K_UP       = 2;
    localparam int K_DOWN     = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cluster_pwr_seq_if ifc();
    logic        busy;
    logic        pow, clk_en, rstn, fetch, done, err;
    logic [63:0] boot_o;
    logic [2:0]  st;

    cluster_pwr_seq #(
        .PWR_CYCLES(P), .CLK_CYCLES(C), .RST_CYCLES(R),
        .BUSY_TIMEOUT(BT), .CNT_W(16)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .req_if                 (ifc.slave),
        .cluster_busy_i         (busy),
        .cluster_pow_o          (pow),
        .cluster_clk_en_o       (clk_en),
        .cluster_rstn_o         (rstn),
        .cluster_fetch_enable_o (fetch),
        .cluster_boot_addr_o    (boot_o),
        .done_o                 (done),
        .err_timeout_o          (err),
        .state_o                (st)
    );

    // Number of rising edges seen so far; read at falling edges
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          t_done;
        int          t0, t1, t2, t3;   // expected last-change cycle of pow, clk_en, rstn, fetch
        logic [63:0] boot;
        logic        err;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_on;
    logic [63:0] m_boot;
    bit          m_err;
    int          busy_until;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: transition tracking, ordering invariants, scoreboard on done
    int   chg[4];
    logic [3:0] prev = 4'b0;
    initial begin
        logic [3:0] cur;
        exp_t e;
        bit lv;
        for (int i = 0; i < 4; i++) chg[i] = 0;
        forever begin
            @(negedge clk);
            cur = {fetch, rstn, clk_en, pow};
            for (int i = 0; i < 4; i++) if (cur[i] !== prev[i]) chg[i] = cyc;
            prev = cur;
            chk("order", {63'd0, ((!pow && clk_en) || (!clk_en && rstn) || (!rstn && fetch))}, 64'd0);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
                end else begin
                    e  = q.pop_front();
                    lv = (e.kind == K_UP) || (e.kind == K_NOOP_RUN);
                    chk("done_cycle", cyc, e.t_done);
                    chk("boot_addr", boot_o, e.boot);
                    chk("err", err, e.err);
                    chk("levels", {fetch, rstn, clk_en, pow}, lv ? 4'hF : 4'h0);
                    chk("state", st, lv ? 3'd4 : 3'd0);
                    if (e.kind == K_UP || e.kind == K_DOWN) begin
                        chk("t_pow",    chg[0], e.t0);
                        chk("t_clk_en", chg[1], e.t1);
                        chk("t_rstn",   chg[2], e.t2);
                        chk("t_fetch",  chg[3], e.t3);
                    end
                end
            end
        end
    end

    // Issue one request; for off-requests busy stays high 'hold' cycles into the drain
    task automatic do_req(input bit on, input logic [63:0] addr, input int hold);
        exp_t e;
        int n, w, k, ex;
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_on    = on;
        ifc.boot_addr = addr;
        w = 0;
        forever begin
            chk("ready", ifc.req_ready, cyc >= busy_until);
            if (ifc.req_ready === 1'b1) break;
            if (w >= 3000) begin
                checks++;
                errors++;
                $display("FAIL ready_wait: got ready=0 expected ready within 3000 cycles");
                ifc.req_valid = 1'b0;
                return;
            end
            @(negedge clk);
            w++;
        end
        n = cyc + 1;   // accepted at the next rising edge
        e.t0 = 0; e.t1 = 0; e.t2 = 0; e.t3 = 0;
        m_err = 1'b0;
        if (m_on && on) begin
            e.kind = K_NOOP_RUN;
            e.t_done = n;
        end else if (m_on) begin
            k  = hold + 1;
            ex = (k < BT) ? k : BT;
            e.kind = K_DOWN;
            e.t3 = n; e.t2 = n + ex; e.t1 = n + ex + R; e.t0 = n + ex + R + P;
            e.t_done = e.t0;
            m_err = (k > BT);
            m_on  = 1'b0;
        end else if (on) begin
            e.kind = K_UP;
            m_boot = addr;
            e.t0 = n; e.t1 = n + P; e.t2 = n + P + C; e.t3 = n + P + C + R;
            e.t_done = e.t3;
            m_on = 1'b1;
        end else begin
            e.kind = K_NOOP_OFF;
            e.t_done = n;
        end
        e.boot = m_boot;
        e.err  = m_err;
        q.push_back(e);
        busy_until = e.t_done;
        if (e.kind == K_DOWN) busy = 1'b1;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        if (e.kind == K_DOWN) begin
            repeat (hold) @(negedge clk);
            busy = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while (q.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got %0d pending expected 0 after 3000 cycles", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        m_on = 1'b0; m_boot = '0; m_err = 1'b0; busy_until = 0;
        chk("rst_levels", {fetch, rstn, clk_en, pow}, 4'h0);
        chk("rst_boot", boot_o, 64'd0);
        chk("rst_done_err", {done, err}, 2'b00);
        chk("rst_state", st, 3'd0);
        chk("rst_ready", ifc.req_ready, 1'b1);
    endtask

    initial begin
        int hold;
        rst = 1'b1;
        busy = 1'b0;
        ifc.req_valid = 1'b0;
        ifc.req_on    = 1'b0;
        ifc.boot_addr = '0;
        m_on = 1'b0; m_boot = '0; m_err = 1'b0; busy_until = 0;
        repeat (2) @(negedge clk);
        do_reset();

        // Power-on, no-op on, power-off with idle cluster, no-op off
        do_req(1'b1, 64'h1C00_8080, 0);   wait_idle();
        do_req(1'b1, 64'hDEAD_BEEF, 0);   wait_idle();
        do_req(1'b0, 64'h0, 0);           wait_idle();
        do_req(1'b0, 64'h0, 0);           wait_idle();

        // Drain waits on busy for 50 cycles
        do_req(1'b1, 64'h1000, 0);        wait_idle();
        do_req(1'b0, 64'h0, 49);          wait_idle();

        // Busy drops exactly on the last drain cycle: normal exit
        do_req(1'b1, 64'h2000, 0);        wait_idle();
        do_req(1'b0, 64'h0, BT - 1);      wait_idle();

        // Stuck busy: timeout, then a fresh power-on clears the error
        do_req(1'b1, 64'h3000, 0);        wait_idle();
        do_req(1'b0, 64'h0, BT + 80);     wait_idle();
        do_req(1'b1, 64'h4000, 0);        wait_idle();

        // Request held during power-up waits for RUN, then completes as a no-op
        do_req(1'b0, 64'h0, 0);           wait_idle();
        do_req(1'b1, 64'h5000, 0);
        do_req(1'b1, 64'h6000, 0);        wait_idle();

        // Reset during CLK_ON, then a clean power-on
        do_req(1'b0, 64'h0, 0);           wait_idle();
        do_req(1'b1, 64'h7000, 0);
        repeat (17) @(negedge clk);
        do_reset();
        do_req(1'b1, 64'h1C00_8080, 0);   wait_idle();

        // Randomized traffic, sometimes back-to-back
        for (int i = 0; i < 24; i++) begin
            hold = ($urandom_range(0, 7) == 0) ? BT + $urandom_range(0, 20) : $urandom_range(0, 60);
            do_req(1'($urandom_range(0, 1)), {$urandom, $urandom}, hold);
            if ($urandom_range(0, 2) != 0) wait_idle();
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no completion expected finish before time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end
endmodule
`default_nettype wire
